// File: rtl/frame_gen_pkg.sv
// Shared encodings for the frame generator / checker pair: pattern selects,
// pixel levels, checker FSM states and a saturating counter helper.
package frame_gen_pkg;

    localparam logic [2:0] SEL_STRAPS = 3'b000;
    localparam logic [2:0] SEL_CHOCO  = 3'b001;
    localparam logic [2:0] SEL_GRAD   = 3'b010;
    localparam logic [2:0] SEL_CHECK  = 3'b011;
    localparam logic [2:0] SEL_CUBES  = 3'b110;
    localparam logic [2:0] SEL_LOGO   = 3'b111;

    localparam logic [7:0] LVL_0 = 8'h00;
    localparam logic [7:0] LVL_1 = 8'h55;
    localparam logic [7:0] LVL_2 = 8'hAA;
    localparam logic [7:0] LVL_3 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_expected_pix.sv
// Combinational expected-pixel model for the analytic patterns (straps and
// checkers); chk_en is low for patterns that carry no value check.
module frame_expected_pix
    import frame_gen_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480
) (
    input  logic [2:0]  sel,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [7:0]  exp,
    output logic        chk_en
);

    localparam logic [31:0] ROWS  = 32'(ROW_COUNT);
    localparam logic [31:0] COL_W = 32'(DVAL_HIGH / 8);
    localparam logic [31:0] ROW_H = (ROW_COUNT / 8 > 0) ? 32'(ROW_COUNT / 8) : 32'd1;

    logic [3:0]  band;
    logic [2:0]  col;
    logic [31:0] row;
    logic        odd;

    always_comb begin
        // Scan downwards so the last hit is the smallest qualifying k.
        band = 4'd15;
        for (int k = 16; k >= 1; k--) begin
            if ({16'd0, y} < (ROWS * 32'(k)) / 32'd16) band = 4'(k - 1);
        end
        col = 3'd7;
        for (int k = 8; k >= 1; k--) begin
            if ({16'd0, x} <= COL_W * 32'(k)) col = 3'(k - 1);
        end
        row = {16'd0, y} / ROW_H;
        odd = ((row + {29'd0, col}) & 32'd1) != 32'd0;

        exp    = LVL_0;
        chk_en = 1'b0;
        case (sel)
            SEL_STRAPS: begin
                chk_en = 1'b1;
                case (band & 4'd3)
                    4'd0:    exp = LVL_0;
                    4'd1:    exp = LVL_1;
                    4'd2:    exp = LVL_2;
                    default: exp = LVL_3;
                endcase
            end
            SEL_CHECK: begin
                chk_en = 1'b1;
                exp    = odd ? LVL_3 : LVL_0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/frame_pattern_checker.sv
// Sink-side checker for the FVAL/LVAL/DVAL video bus: recovers coordinates,
// checks geometry and pattern pixels. FRAME_PATTERN_CHECKER_CHECKSUM_EN adds a per-frame pixel sum.
module frame_pattern_checker
    import frame_gen_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic        fval,
    input  logic        lval,
    input  logic        dval,
    input  logic [7:0]  pix_value,
    output logic        frame_done,
    output logic [15:0] line_cnt,
    output logic [15:0] short_line_cnt,
    output logic [15:0] pix_err_cnt,
    output logic        geom_err,
    output logic        proto_err,
    output logic [31:0] frame_checksum,
    output state_t      fsm_state
);

    localparam logic [31:0] PIX_PER_LINE = 32'(DVAL_HIGH);
    localparam logic [31:0] LINES        = 32'(ROW_COUNT);

    state_t      state, state_nxt;
    logic        fval_d, lval_d, dval_d, armed;
    logic        fval_rise, fval_fall, lval_rise, lval_fall;
    logic        clear, close, commit, restart_err, count_dval, proto_set;
    logic [2:0]  sel_q;
    logic [15:0] x, y, short_cnt, err_cnt, x_s, y_s, x_end;
    logic        samp_v, pix_sample, pix_bad, chk_en;
    logic [7:0]  exp_pix;

    assign fval_rise = fval & ~fval_d;
    assign fval_fall = ~fval & fval_d;
    assign lval_rise = lval & ~lval_d;
    assign lval_fall = ~lval & lval_d;
    assign fsm_state = state;

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        close       = 1'b0;
        commit      = 1'b0;
        restart_err = 1'b0;
        case (state)
            IDLE: if (fval_rise && armed) begin
                state_nxt = FRAME;
                clear     = 1'b1;
            end
            FRAME: begin
                if (fval_fall)      state_nxt = DONE;
                else if (lval_rise) state_nxt = LINE;
            end
            LINE: begin
                if (fval_fall || lval_fall) close = 1'b1;
                if (fval_fall)      state_nxt = DONE;
                else if (lval_fall) state_nxt = FRAME;
            end
            DONE: begin
                // A one-cycle FVAL drop inside a line surfaces here as a rise
                // while LVAL is still high: drop the frame and start over.
                if (fval_rise && lval && lval_d) begin
                    restart_err = 1'b1;
                    clear       = 1'b1;
                    state_nxt   = FRAME;
                end else begin
                    commit = 1'b1;
                    if (fval_rise) begin
                        clear     = 1'b1;
                        state_nxt = FRAME;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first DVAL of a line can coincide with the LVAL rise seen in FRAME.
    assign count_dval = dval & lval & ((state == LINE) | ((state == FRAME) & lval_rise));
    assign x_end      = count_dval ? sat_inc16(x) : x;
    assign proto_set  = (~fval & (lval | dval)) | restart_err;
    assign pix_sample = dval_d & samp_v;
    assign pix_bad    = pix_sample & chk_en & (pix_value != exp_pix);

    frame_expected_pix #(
        .DVAL_HIGH (DVAL_HIGH),
        .ROW_COUNT (ROW_COUNT)
    ) u_exp (
        .sel    (sel_q),
        .x      (x_s),
        .y      (y_s),
        .exp    (exp_pix),
        .chk_en (chk_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            fval_d         <= 1'b0;
            lval_d         <= 1'b0;
            dval_d         <= 1'b0;
            armed          <= 1'b0;
            sel_q          <= '0;
            x              <= '0;
            y              <= '0;
            short_cnt      <= '0;
            err_cnt        <= '0;
            x_s            <= '0;
            y_s            <= '0;
            samp_v         <= 1'b0;
            frame_done     <= 1'b0;
            line_cnt       <= '0;
            short_line_cnt <= '0;
            pix_err_cnt    <= '0;
            geom_err       <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            fval_d     <= fval;
            lval_d     <= lval;
            dval_d     <= dval;
            armed      <= armed | ~fval;
            state      <= state_nxt;
            frame_done <= commit;
            samp_v     <= count_dval;
            if (proto_set) proto_err <= 1'b1;
            if (count_dval) begin
                x_s <= x;
                y_s <= y;
            end
            if (clear) begin
                sel_q     <= sel;
                x         <= '0;
                y         <= '0;
                short_cnt <= '0;
                err_cnt   <= '0;
            end else begin
                if (close) begin
                    x <= '0;
                    y <= sat_inc16(y);
                    if ({16'd0, x_end} != PIX_PER_LINE) short_cnt <= sat_inc16(short_cnt);
                end else if (count_dval) begin
                    x <= x_end;
                end
                if (pix_bad) err_cnt <= sat_inc16(err_cnt);
            end
            if (commit) begin
                line_cnt       <= y;
                short_line_cnt <= short_cnt;
                pix_err_cnt    <= err_cnt;
                geom_err       <= ({16'd0, y} != LINES) || (short_cnt != 16'd0);
            end
        end
    end

`ifdef FRAME_PATTERN_CHECKER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum            <= '0;
            frame_checksum <= '0;
        end else begin
            if (clear)           sum <= '0;
            else if (pix_sample) sum <= sum + {24'd0, pix_value};
            if (commit) frame_checksum <= sum;
        end
    end
`else
    assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_frame_pattern_checker.sv
// Self-checking bench for frame_pattern_checker on a 16x16 geometry.
module tb_frame_pattern_checker;
    import frame_gen_pkg::*;

    localparam int DH = 16;
    localparam int RC = 16;
    localparam int W  = 81;
`ifdef FRAME_PATTERN_CHECKER_CHECKSUM_EN
    localparam bit CKS_ON = 1'b1;
`else
    localparam bit CKS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic        fval, lval, dval;
    logic [7:0]  pix_value;
    logic        frame_done;
    logic [15:0] line_cnt, short_line_cnt, pix_err_cnt;
    logic        geom_err, proto_err;
    logic [31:0] frame_checksum;
    state_t      fsm_state;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int pushed = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   pend = 8'h00;
    logic [31:0]  sum_m = 32'd0;

    typedef struct {
        logic [2:0] s;
        int nl; int sy; int slen; int ex; int ey;
        int lc; int sh; int er; logic geom;
    } rec_t;
    rec_t tbl[7];

    always #5 clk = ~clk;

    frame_pattern_checker #(.DVAL_HIGH(DH), .ROW_COUNT(RC)) dut (
        .clk(clk), .rst(rst), .sel(sel), .fval(fval), .lval(lval), .dval(dval),
        .pix_value(pix_value), .frame_done(frame_done), .line_cnt(line_cnt),
        .short_line_cnt(short_line_cnt), .pix_err_cnt(pix_err_cnt),
        .geom_err(geom_err), .proto_err(proto_err),
        .frame_checksum(frame_checksum), .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Closed-form reference for the 16x16 geometry: 2-px checker columns, 2-line rows.
    function automatic logic [7:0] model_pix(input logic [2:0] s, input int x, input int y);
        int c;
        if (s == SEL_STRAPS) return 8'h55 * 8'(y % 4);
        if (s == SEL_CHECK) begin
            c = (x == 0) ? 0 : (x - 1) / 2;
            return (((y / 2) + c) % 2 == 1) ? 8'hFF : 8'h00;
        end
        return 8'h01;
    endfunction

    // Pixel for a DVAL cycle appears on the bus one clock later.
    task automatic drive(input logic f, input logic l, input logic d, input logic [7:0] p);
        fval = f; lval = l; dval = d; pix_value = pend;
        if (d) pend = p;
        @(posedge clk); #1;
    endtask

    task automatic send_line(input int npx, input int y, input logic [2:0] s, input int ex, input int ey);
        logic [7:0] p;
        for (int x = 0; x < npx; x++) begin
            p = model_pix(s, x, y);
            if (x == ex && y == ey) p = ~p;
            sum_m = sum_m + {24'd0, p};
            drive(1'b1, 1'b1, 1'b1, p);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_exp(input int lc, input int sh, input int er, input logic g);
        exp_q.push_back({16'(lc), 16'(sh), 16'(er), g, CKS_ON ? sum_m : 32'd0});
        pushed++;
    endtask

    task automatic send_frame(input rec_t r);
        sel = r.s; sum_m = 32'd0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        sel = ~r.s;  // selection must have been latched at the rise
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int y = 0; y < r.nl; y++) send_line((y == r.sy) ? r.slen : DH, y, r.s, r.ex, r.ey);
        push_exp(r.lc, r.sh, r.er, r.geom);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && frame_done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("line_cnt", {16'd0, line_cnt}, {16'd0, e[80:65]});
                check("short_line_cnt", {16'd0, short_line_cnt}, {16'd0, e[64:49]});
                check("pix_err_cnt", {16'd0, pix_err_cnt}, {16'd0, e[48:33]});
                check("geom_err", {31'd0, geom_err}, {31'd0, e[32]});
                check("frame_checksum", frame_checksum, e[31:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{SEL_STRAPS, 16, -1, 0, -1, -1, 16, 0, 0, 1'b0};
        tbl[1] = '{SEL_CHECK,  16, -1, 0,  5,  3, 16, 0, 1, 1'b0};
        tbl[2] = '{SEL_GRAD,   16, -1, 0, -1, -1, 16, 0, 0, 1'b0};
        tbl[3] = '{SEL_STRAPS, 15,  7, 15, -1, -1, 15, 1, 0, 1'b1};
        tbl[4] = '{SEL_STRAPS, 16,  0, 17, -1, -1, 16, 1, 0, 1'b1};
        tbl[5] = '{SEL_CHECK,  16, -1, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 16, 0, 1, 1'b0};
        tbl[6] = '{SEL_GRAD,   16, -1, 0,  5,  5, 16, 0, 0, 1'b0};

        rst = 1'b1; sel = 3'd0; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_value = 8'h00;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i]);
            drain();
            if (i == 2) check("checksum_256", frame_checksum, CKS_ON ? 32'd256 : 32'd0);
        end
        check("proto_clean", {31'd0, proto_err}, 32'd0);

        // FVAL glitch inside line 3: frame dropped, restart counts from the next line.
        sel = SEL_STRAPS;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int y = 0; y < 3; y++) send_line(DH, y, SEL_STRAPS, -1, -1);
        for (int x = 0; x < 5; x++) drive(1'b1, 1'b1, 1'b1, model_pix(SEL_STRAPS, x, 3));
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int x = 5; x < DH; x++) drive(1'b1, 1'b1, 1'b1, 8'h5A);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("proto_glitch", {31'd0, proto_err}, 32'd1);
        check("no_done_abandoned", 32'(done_seen), 32'(pushed));
        sum_m = 32'd0;
        for (int y = 0; y < RC; y++) send_line(DH, y, SEL_STRAPS, -1, -1);
        push_exp(16, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drain();
        check("proto_sticky", {31'd0, proto_err}, 32'd1);

        // Reset mid-line with FVAL held high across release.
        sel = SEL_CHECK;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int y = 0; y < 2; y++) send_line(DH, y, SEL_CHECK, -1, -1);
        for (int x = 0; x < 6; x++) drive(1'b1, 1'b1, 1'b1, model_pix(SEL_CHECK, x, 2));
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        check("mid_rst_line_cnt", {16'd0, line_cnt}, 32'd0);
        check("mid_rst_short", {16'd0, short_line_cnt}, 32'd0);
        check("mid_rst_err", {16'd0, pix_err_cnt}, 32'd0);
        check("mid_rst_geom", {31'd0, geom_err}, 32'd0);
        check("mid_rst_proto", {31'd0, proto_err}, 32'd0);
        check("mid_rst_checksum", frame_checksum, 32'd0);
        rst = 1'b0;
        for (int x = 0; x < 5; x++) drive(1'b1, 1'b1, 1'b1, 8'h33);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_line(DH, 3, SEL_CHECK, -1, -1);
        check("not_armed_state", {30'd0, fsm_state}, {30'd0, IDLE});
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("no_done_after_rst", 32'(done_seen), 32'(pushed));
        send_frame(tbl[1]);
        drain();
        check("proto_after_rst", {31'd0, proto_err}, 32'd0);
        check("done_count", 32'(done_seen), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
